// File: rtl/alu_pkg.sv
// alu_pkg: func codes, flag bit indices and FSM states shared by the ALU
package alu_pkg;
  localparam logic [3:0] FN_NOP  = 4'h0;
  localparam logic [3:0] FN_SETC = 4'h1;
  localparam logic [3:0] FN_CLRC = 4'h2;
  localparam logic [3:0] FN_MOV1 = 4'h3;
  localparam logic [3:0] FN_MOV2 = 4'h4;
  localparam logic [3:0] FN_NOT  = 4'h5;
  localparam logic [3:0] FN_INC  = 4'h6;
  localparam logic [3:0] FN_DEC  = 4'h7;
  localparam logic [3:0] FN_ADD  = 4'h8;
  localparam logic [3:0] FN_SUB  = 4'h9;
  localparam logic [3:0] FN_AND  = 4'hA;
  localparam logic [3:0] FN_OR   = 4'hB;
  localparam logic [3:0] FN_SHL  = 4'hC;
  localparam logic [3:0] FN_SHR  = 4'hD;
  localparam logic [3:0] FN_MUL  = 4'hE;
  localparam logic [3:0] FN_RSV  = 4'hF;
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  typedef enum logic {ST_IDLE, ST_MUL} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add unsigned multiplier, one partial product per cycle
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] r_mcand, r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  assign done    = r_busy && (r_cnt == CW'(WIDTH));
  assign product = r_acc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (abort) begin
      r_busy <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (done) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with Z/N/C flag register, valid/ready handshake, flush
// and an iterative multiply that holds off new work while it runs.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             flags_we,
  input  logic             flag_load,
  input  logic [2:0]       flag_in,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags
);
  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);
  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_result, w_mres;
  logic [2:0]         r_flags, w_flags_nxt;
  logic               r_out_valid, r_mul_fwe;
  logic               w_accept, w_single, w_mul_start, w_mul_done, w_mul_fin, w_zn, w_cupd;
  logic [WIDTH:0]     w_sum, w_shr;
  logic [SHAMT_W-1:0] w_s;
  logic [2*WIDTH-1:0] w_prod;
  assign in_ready    = r_state == ST_IDLE;
  assign w_accept    = in_valid & in_ready & ~flush;
  assign w_mul_start = w_accept & (func == FN_MUL);
  assign w_single    = w_accept & (func != FN_MUL);
  assign w_mul_fin   = w_mul_done & ~flush;
  assign w_mres      = w_prod[WIDTH-1:0];
  assign w_s         = op2[SHAMT_W-1:0];
  assign w_shr       = {op1, 1'b0} >> w_s;
  assign w_state_nxt = (r_state == ST_IDLE) ? (w_mul_start ? ST_MUL : ST_IDLE)
                                            : ((flush | w_mul_done) ? ST_IDLE : ST_MUL);
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign flags       = r_flags;
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .abort   (flush),
    .a       (op1),
    .b       (op2),
    .done    (w_mul_done),
    .product (w_prod)
  );
  // Bit WIDTH of w_sum carries C (carry, borrow or the bit shifted out)
  always_comb begin
    w_sum  = '0;
    w_zn   = 1'b1;
    w_cupd = 1'b0;
    case (func)
      FN_MOV1: w_sum = {1'b0, op1};
      FN_MOV2: w_sum = {1'b0, op2};
      FN_NOT:  w_sum = {1'b0, ~op1};
      FN_INC:  begin w_sum = {1'b0, op1} + ONE; w_cupd = 1'b1; end
      FN_DEC:  begin w_sum = {1'b0, op1} - ONE; w_cupd = 1'b1; end
      FN_ADD:  begin w_sum = {1'b0, op1} + {1'b0, op2}; w_cupd = 1'b1; end
      FN_SUB:  begin w_sum = {1'b0, op1} - {1'b0, op2}; w_cupd = 1'b1; end
      FN_AND:  w_sum = {1'b0, op1 & op2};
      FN_OR:   w_sum = {1'b0, op1 | op2};
      FN_SHL:  begin w_sum = {1'b0, op1} << w_s; w_cupd = 1'b1; end
      FN_SHR:  begin w_sum = {w_shr[0], w_shr[WIDTH:1]}; w_cupd = 1'b1; end
      default: w_zn = 1'b0;
    endcase
  end
  always_comb begin
    w_flags_nxt = r_flags;
    if (flag_load)
      w_flags_nxt = flag_in;
    else if (w_mul_fin & r_mul_fwe)
      w_flags_nxt = {|w_prod[2*WIDTH-1:WIDTH], w_mres[WIDTH-1], w_mres == '0};
    else if (w_accept & (func == FN_SETC))
      w_flags_nxt[FLG_C] = 1'b1;
    else if (w_accept & (func == FN_CLRC))
      w_flags_nxt[FLG_C] = 1'b0;
    else if (w_accept & flags_we & w_zn) begin
      w_flags_nxt[FLG_Z] = w_sum[WIDTH-1:0] == '0;
      w_flags_nxt[FLG_N] = w_sum[WIDTH-1];
      w_flags_nxt[FLG_C] = w_cupd ? w_sum[WIDTH] : r_flags[FLG_C];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_flags     <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_mul_fwe   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flags     <= w_flags_nxt;
      r_out_valid <= w_mul_fin | w_single;
      if (w_mul_fin) r_result <= w_mres;
      else if (w_single) r_result <= w_sum[WIDTH-1:0];
      if (w_mul_start) r_mul_fwe <= flags_we;
    end
  end
endmodule
